graph_edge_fetch: RTL and testbench
===================================

Name: graph_edge_fetch

Overview:
- Adjacency-list memory and edge streamer that sits directly upstream of the path-counting control core.
- The core issues a node index; this block looks up that node's successor list and streams one successor per beat, together with a remaining-edge count.
- Graph contents are loaded through a configuration port before a run. The block holds the CSR-style offset table and the edge table.

Parameters:
PARAM_NODE_IDX_WIDTH, 10, width of node index; offset table depth = 2**PARAM_NODE_IDX_WIDTH
PARAM_COUNTER_WIDTH, 4, width of per-node edge count; max 2**W-1 edges per node
PARAM_EDGE_ADDR_WIDTH, 12, edge table address width; depth = 2**PARAM_EDGE_ADDR_WIDTH

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
cfg_off_we  in  1  offset table write strobe
cfg_off_node  in  NODE_IDX_WIDTH  offset table write address
cfg_off_base  in  EDGE_ADDR_WIDTH  first edge address for node
cfg_off_cnt  in  COUNTER_WIDTH  number of edges for node
cfg_edge_we  in  1  edge table write strobe
cfg_edge_addr  in  EDGE_ADDR_WIDTH  edge table write address
cfg_edge_data  in  NODE_IDX_WIDTH  successor node index
req_valid  in  1  lookup request
req_ready  out  1  block can accept request
node_idx  in  NODE_IDX_WIDTH  node to expand
rsp_valid  out  1  successor beat valid
rsp_ready  in  1  consumer accepts beat
next_node_idx  out  NODE_IDX_WIDTH  successor node index
next_node_counter  out  COUNTER_WIDTH  edges remaining after this beat
rsp_last  out  1  final beat of this node
rsp_empty  out  1  node has zero successors
busy  out  1  state != IDLE

Behaviour:
- Reset (sync, rst_n=0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0, except req_ready=1 when no cfg strobe is active.
  - base/remaining registers clear to 0.
  - Memory contents are NOT reset.
  - Reset mid-stream abandons the node; rsp_valid=0 from the next cycle.
- Memories: both tables are synchronous-read; an address applied in cycle N gives data in cycle N+1. One write port each.
- Config writes:
  - Honoured only in IDLE; ignored in any other state.
  - req_ready = (state==IDLE) & !cfg_off_we & !cfg_edge_we, so config has priority over a simultaneous request.
- FSM states: IDLE, RD_OFFSET, RD_EDGE, PRESENT.
  - IDLE: on req_valid&req_ready, apply node_idx to the offset table and go to RD_OFFSET.
  - RD_OFFSET: latch base and cnt.
    - cnt==0: go to PRESENT with next_node_idx=0, counter=0, rsp_last=1, rsp_empty=1.
    - Otherwise: apply base to the edge table, set remaining=cnt-1, go to RD_EDGE.
  - RD_EDGE: latch edge data into next_node_idx, counter=remaining, rsp_last=(remaining==0), rsp_empty=0; go to PRESENT.
  - PRESENT: rsp_valid=1; all rsp outputs are held stable until rsp_ready.
    - On handshake with rsp_last=1: go to IDLE.
    - Otherwise: apply addr+1 to the edge table, decrement remaining, go to RD_EDGE.
- Latency:
  - Request accepted cycle 0 -> first rsp_valid in cycle 3 (cycle 2 for a zero-edge node).
  - Beat handshake cycle k -> next rsp_valid at cycle k+2; throughput is 1 edge per 2 cycles.
  - After the last handshake, req_ready=1 in the next cycle.
- Arithmetic:
  - Edge address increments modulo 2**EDGE_ADDR_WIDTH, so a list may wrap past the top of the table.
  - remaining never underflows; it is not decremented when last.
- A request with req_valid high while busy is not accepted; the requester must hold it.

Test Plan:
- Load node 5: base=100, cnt=3; edges[100..102]=7,9,11. Request 5 with rsp_ready=1 -> beats (7,2,last0), (9,1,last0), (11,0,last1); first rsp_valid 3 cycles after accept, subsequent beats 2 cycles apart; busy drops after the final handshake.
- Same node 5 with rsp_ready low for 4 cycles on beat 2 -> beat (9,1) held stable throughout the stall; no beat lost or duplicated.
- Node 8: cnt=0 -> single beat in cycle 2: next_node_idx=0, counter=0, rsp_last=1, rsp_empty=1; back to IDLE.
- Node 3: base=4095, cnt=2; edges[4095]=20, edges[0]=21 -> beats (20,1), (21,0,last); address wraps to 0.
- cfg_edge_we and req_valid asserted in the same IDLE cycle -> req_ready=0, write committed, request accepted next cycle. cfg write issued while busy -> memory unchanged, verified by re-read.
- rst_n=0 for one cycle during beat 2 of node 5 -> next cycle: IDLE, rsp_valid=0, req_ready=1. Re-request node 5 -> full correct 3-beat stream (memory retained).

Source files
------------

// File: rtl/graph_edge_fetch.sv
// Adjacency-list store and successor streamer: loads a CSR offset/edge graph via the
// cfg port, then expands one requested node into a stream of successor beats.
module graph_edge_fetch #(
    parameter int PARAM_NODE_IDX_WIDTH  = 10,
    parameter int PARAM_COUNTER_WIDTH   = 4,
    parameter int PARAM_EDGE_ADDR_WIDTH = 12
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg_off_we,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0]  cfg_off_node,
    input  logic [PARAM_EDGE_ADDR_WIDTH-1:0] cfg_off_base,
    input  logic [PARAM_COUNTER_WIDTH-1:0]   cfg_off_cnt,
    input  logic                             cfg_edge_we,
    input  logic [PARAM_EDGE_ADDR_WIDTH-1:0] cfg_edge_addr,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0]  cfg_edge_data,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0]  node_idx,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [PARAM_NODE_IDX_WIDTH-1:0]  next_node_idx,
    output logic [PARAM_COUNTER_WIDTH-1:0]   next_node_counter,
    output logic                             rsp_last,
    output logic                             rsp_empty,
    output logic                             busy
);

    localparam int NW         = PARAM_NODE_IDX_WIDTH;
    localparam int CW         = PARAM_COUNTER_WIDTH;
    localparam int AW         = PARAM_EDGE_ADDR_WIDTH;
    localparam int OFF_DEPTH  = 1 << NW;
    localparam int EDGE_DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE,
        RD_OFFSET,
        RD_EDGE,
        PRESENT
    } state_t;

    typedef struct packed {
        logic [AW-1:0] base;
        logic [CW-1:0] cnt;
    } off_entry_t;

    state_t        state_q;
    off_entry_t    off_mem  [OFF_DEPTH];
    logic [NW-1:0] edge_mem [EDGE_DEPTH];
    off_entry_t    off_rd_q;
    logic [NW-1:0] edge_rd_q;
    logic [AW-1:0] edge_addr_q;
    logic [AW-1:0] edge_rd_addr;
    logic [CW-1:0] remaining_q;
    logic          cfg_active;
    logic          accept;
    logic          cfg_allowed;

    assign cfg_active  = cfg_off_we | cfg_edge_we;
    assign req_ready   = (state_q == IDLE) && !cfg_active;
    assign busy        = (state_q != IDLE);
    assign accept      = req_valid && req_ready;
    assign cfg_allowed = (state_q == IDLE);

    // NOTE: the tables have no reset branch; clearing thousands of entries is never
    // needed because contents are always loaded before use and survive rst_n.
    // NOTE: every clocked block uses <= so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (cfg_off_we && cfg_allowed) begin
            off_mem[cfg_off_node] <= '{base: cfg_off_base, cnt: cfg_off_cnt};
        end
        if (cfg_edge_we && cfg_allowed) begin
            edge_mem[cfg_edge_addr] <= cfg_edge_data;
        end
        // Synchronous reads: the offset port follows node_idx so the accept edge
        // captures the requested entry; the edge port follows edge_rd_addr.
        off_rd_q  <= off_mem[node_idx];
        edge_rd_q <= edge_mem[edge_rd_addr];
    end

    // While PRESENT stalls the edge port keeps re-reading addr+1, so whatever is
    // captured on the handshake edge is already the next successor.
    always_comb begin
        // NOTE: default first so every path assigns edge_rd_addr and no latch appears.
        edge_rd_addr = edge_addr_q + AW'(1);
        if (state_q == RD_OFFSET) begin
            edge_rd_addr = off_rd_q.base;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            edge_addr_q       <= '0;
            remaining_q       <= '0;
            rsp_valid         <= 1'b0;
            next_node_idx     <= '0;
            next_node_counter <= '0;
            rsp_last          <= 1'b0;
            rsp_empty         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= RD_OFFSET;
                    end
                end
                RD_OFFSET: begin
                    edge_addr_q <= off_rd_q.base;
                    if (off_rd_q.cnt == '0) begin
                        remaining_q       <= '0;
                        next_node_idx     <= '0;
                        next_node_counter <= '0;
                        rsp_last          <= 1'b1;
                        rsp_empty         <= 1'b1;
                        rsp_valid         <= 1'b1;
                        state_q           <= PRESENT;
                    end else begin
                        remaining_q <= off_rd_q.cnt - CW'(1);
                        state_q     <= RD_EDGE;
                    end
                end
                RD_EDGE: begin
                    next_node_idx     <= edge_rd_q;
                    next_node_counter <= remaining_q;
                    rsp_last          <= (remaining_q == '0);
                    rsp_empty         <= 1'b0;
                    rsp_valid         <= 1'b1;
                    state_q           <= PRESENT;
                end
                PRESENT: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_last) begin
                            state_q <= IDLE;
                        end else begin
                            // Address wraps naturally at the top of the edge table.
                            edge_addr_q <= edge_addr_q + AW'(1);
                            remaining_q <= remaining_q - CW'(1);
                            state_q     <= RD_EDGE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_graph_edge_fetch.sv
// Scoreboard bench for graph_edge_fetch: stimulus pushes expected beats, a negedge
// monitor pops and compares them and checks beat latency, stall stability and idle return.
module tb_graph_edge_fetch;

    localparam int NW = 10;
    localparam int CW = 4;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_off_we = 1'b0;
    logic [NW-1:0] cfg_off_node = '0;
    logic [AW-1:0] cfg_off_base = '0;
    logic [CW-1:0] cfg_off_cnt = '0;
    logic          cfg_edge_we = 1'b0;
    logic [AW-1:0] cfg_edge_addr = '0;
    logic [NW-1:0] cfg_edge_data = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [NW-1:0] node_idx = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [NW-1:0] next_node_idx;
    logic [CW-1:0] next_node_counter;
    logic          rsp_last;
    logic          rsp_empty;
    logic          busy;

    graph_edge_fetch #(
        .PARAM_NODE_IDX_WIDTH (NW),
        .PARAM_COUNTER_WIDTH  (CW),
        .PARAM_EDGE_ADDR_WIDTH(AW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_off_we       (cfg_off_we),
        .cfg_off_node     (cfg_off_node),
        .cfg_off_base     (cfg_off_base),
        .cfg_off_cnt      (cfg_off_cnt),
        .cfg_edge_we      (cfg_edge_we),
        .cfg_edge_addr    (cfg_edge_addr),
        .cfg_edge_data    (cfg_edge_data),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .node_idx         (node_idx),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .next_node_idx    (next_node_idx),
        .next_node_counter(next_node_counter),
        .rsp_last         (rsp_last),
        .rsp_empty        (rsp_empty),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int cnt;
        bit last;
        bit empty;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    bit    armed = 0;
    bit    from_accept = 0;
    bit    prev_valid = 0;
    bit    prev_stall = 0;
    bit    idle_due = 0;
    int    evt_cyc = 0;
    beat_t held;
    beat_t got;

    always @(negedge clk) begin
        if (!rst_n) begin
            armed      = 0;
            prev_valid = 0;
            prev_stall = 0;
            idle_due   = 0;
        end else begin
            if (idle_due) begin
                check("idle_busy", int'(busy), 0);
                check("idle_req_ready", int'(req_ready), 1);
                idle_due = 0;
            end
            if (prev_stall) begin
                check("stall_valid", int'(rsp_valid), 1);
                check("stall_idx", int'(next_node_idx), held.idx);
                check("stall_counter", int'(next_node_counter), held.cnt);
                check("stall_last", int'(rsp_last), int'(held.last));
            end
            if (rsp_valid && !prev_valid) begin
                if (exp_q.size() == 0)
                    check("unexpected_beat", 1, 0);
                else if (armed)
                    check("beat_latency", cyc - evt_cyc,
                          (from_accept && !exp_q[0].empty) ? 3 : 2);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() != 0) begin
                    got = exp_q.pop_front();
                    check("beat_idx", int'(next_node_idx), got.idx);
                    check("beat_counter", int'(next_node_counter), got.cnt);
                    check("beat_last", int'(rsp_last), int'(got.last));
                    check("beat_empty", int'(rsp_empty), int'(got.empty));
                    if (got.last) idle_due = 1;
                end
                evt_cyc     = cyc;
                from_accept = 0;
            end
            if (req_valid && req_ready) begin
                evt_cyc     = cyc;
                from_accept = 1;
                armed       = 1;
            end
            prev_stall = rsp_valid && !rsp_ready;
            held       = '{int'(next_node_idx), int'(next_node_counter), rsp_last, rsp_empty};
            prev_valid = rsp_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_off(input int node, input int base, input int cnt);
        cfg_off_we   = 1'b1;
        cfg_off_node = NW'(node);
        cfg_off_base = AW'(base);
        cfg_off_cnt  = CW'(cnt);
        tick();
        cfg_off_we = 1'b0;
    endtask

    task automatic cfg_edge(input int addr, input int data);
        cfg_edge_we   = 1'b1;
        cfg_edge_addr = AW'(addr);
        cfg_edge_data = NW'(data);
        tick();
        cfg_edge_we = 1'b0;
    endtask

    task automatic push(input int idx, input int cnt, input bit last, input bit empty);
        exp_q.push_back('{idx, cnt, last, empty});
    endtask

    task automatic push_node5();
        push(7, 2, 0, 0);
        push(9, 1, 0, 0);
        push(11, 0, 1, 0);
    endtask

    task automatic issue(input int node);
        bit ok = 0;
        req_valid = 1'b1;
        node_idx  = NW'(node);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        tick();
        req_valid = 1'b0;
        if (!ok) check("req_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || rsp_valid || exp_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            check({name, "_timeout"}, 0, 1);
            exp_q.delete();
        end
        tick();
        tick();
    endtask

    task automatic wait_beat(input int idx, input string name);
        int n = 0;
        while (!(rsp_valid && int'(next_node_idx) == idx) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check({name, "_timeout"}, 0, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) tick();
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_last", int'(rsp_last), 0);
        check("rst_empty", int'(rsp_empty), 0);
        check("rst_counter", int'(next_node_counter), 0);
        rst_n = 1'b1;
        tick();

        cfg_off(5, 100, 3);
        cfg_edge(100, 7);
        cfg_edge(101, 9);
        cfg_edge(102, 11);
        cfg_off(8, 0, 0);
        cfg_off(3, 4095, 2);
        cfg_edge(4095, 20);
        cfg_edge(0, 21);
        cfg_off(12, 200, 1);

        // Free-running three-beat list.
        push_node5();
        issue(5);
        wait_idle("node5_stream");

        // Consumer stalls four cycles on the second beat.
        push_node5();
        issue(5);
        wait_beat(9, "stall_beat2");
        rsp_ready = 1'b0;
        repeat (4) tick();
        rsp_ready = 1'b1;
        wait_idle("node5_stall");

        // Zero-successor node.
        push(0, 0, 1, 1);
        issue(8);
        wait_idle("node8_empty");

        // List wrapping past the top of the edge table.
        push(20, 1, 0, 0);
        push(21, 0, 1, 0);
        issue(3);
        wait_idle("node3_wrap");

        // Config write and request in the same idle cycle: config wins.
        cfg_edge_we   = 1'b1;
        cfg_edge_addr = AW'(200);
        cfg_edge_data = NW'(33);
        req_valid     = 1'b1;
        node_idx      = NW'(12);
        @(negedge clk);
        check("cfg_prio_req_ready", int'(req_ready), 0);
        tick();
        cfg_edge_we = 1'b0;
        push(33, 0, 1, 0);
        @(negedge clk);
        check("req_ready_after_cfg", int'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        wait_idle("node12_cfg_prio");

        // Config writes while busy must be dropped.
        rsp_ready = 1'b0;
        push(33, 0, 1, 0);
        issue(12);
        check("busy_during_cfg", int'(busy), 1);
        cfg_edge(200, 44);
        cfg_off(12, 300, 5);
        repeat (3) tick();
        rsp_ready = 1'b1;
        wait_idle("node12_busy_cfg");
        push(33, 0, 1, 0);
        issue(12);
        wait_idle("node12_reread");

        // Reset during the second beat abandons the node; memory survives.
        push_node5();
        issue(5);
        wait_beat(9, "reset_beat2");
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        check("midrst_rsp_valid", int'(rsp_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_req_ready", int'(req_ready), 1);
        rst_n = 1'b1;
        tick();
        push_node5();
        issue(5);
        wait_idle("node5_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
